// File: rtl/asm_run_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : asm_run_counter_if
//  Description : Control/status bundle for the ASM run counter. The master
//                drives start/x/target/ack, the slave returns count/busy/done
//                and the state code.
//  Revision    : 1.0 - initial release
// ============================================================================
interface asm_run_counter_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             x;
    logic [WIDTH-1:0] target;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, x, target, ack,
        input  count, busy, done, state
    );

    modport slave (
        input  start, x, target, ack,
        output count, busy, done, state
    );
endinterface
`default_nettype wire

// File: rtl/asm_run_counter.sv
`default_nettype none
// ============================================================================
//  Module      : asm_run_counter
//  Description : Registered Moore FSM (IDLE/ARM/RUN) that counts cycles with
//                x=1 up to a latched terminal count and raises a sticky done.
//                MODE=0 keeps the count across x gaps, MODE=1 clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
module asm_run_counter #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0
) (
    input  wire                    clk,
    input  wire                    reset,
    asm_run_counter_if.slave       bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Next-state and next-output computation; every output is a register.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        done_d   = done_q;

        // ack clears done everywhere; any set below overrides the clear.
        if (bus.ack) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    count_d = '0;
                    if (bus.target != '0) begin
                        target_d = bus.target;
                        done_d   = 1'b0;
                        state_d  = S_ARM;
                    end else begin
                        // Zero-length measurement completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (bus.x) begin
                    count_d = count_q + C_ONE;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Terminal count wins over x, so count can never pass target.
                if (count_q == target_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (bus.x) begin
                    count_d = count_q + C_ONE;
                end else begin
                    state_d = S_ARM;
                    if (MODE == 1) begin
                        count_d = '0;
                    end
                end
            end
            default: begin
                // Unused code: fall back to IDLE leaving count/done alone.
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ARM) || (state_d == S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            target_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_asm_run_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asm_run_counter
//  Description : Self-checking bench for asm_run_counter (WIDTH=4), with one
//                MODE=0 and one MODE=1 instance driven by the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asm_run_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         x;
    logic         ack;
    logic [W-1:0] target;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    asm_run_counter_if #(.WIDTH(W)) bus0 ();
    asm_run_counter_if #(.WIDTH(W)) bus1 ();

    assign bus0.start  = start;
    assign bus0.x      = x;
    assign bus0.ack    = ack;
    assign bus0.target = target;
    assign bus1.start  = start;
    assign bus1.x      = x;
    assign bus1.ack    = ack;
    assign bus1.target = target;

    asm_run_counter #(.WIDTH(W), .MODE(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    asm_run_counter #(.WIDTH(W), .MODE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // Vector record: inputs, then expected state/count/done for each mode.
    typedef struct {
        logic         rst;
        logic         st;
        logic         xx;
        logic [W-1:0] tg;
        logic         ak;
        logic [1:0]   s0;
        logic [W-1:0] c0;
        logic         d0;
        logic [1:0]   s1;
        logic [W-1:0] c1;
        logic         d1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic st, input logic xx,
                       input logic [W-1:0] tg, input logic ak,
                       input logic [1:0] s0, input logic [W-1:0] c0, input logic d0,
                       input logic [1:0] s1, input logic [W-1:0] c1, input logic d1);
        vec_t v;
        v.rst = rst; v.st = st; v.xx = xx; v.tg = tg; v.ak = ak;
        v.s0 = s0; v.c0 = c0; v.d0 = d0;
        v.s1 = s1; v.c1 = c1; v.d1 = d1;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [1:0] s, input logic [W-1:0] c, input logic d, input logic b,
                       input logic [1:0] es, input logic [W-1:0] ec, input logic ed);
        logic eb;
        eb = (es == 2'd1) || (es == 2'd2);
        total++;
        if (s !== es || c !== ec || d !== ed || b !== eb) begin
            $display("FAIL %s dut%0d: got state=%0d count=%0d done=%0b busy=%0b, want state=%0d count=%0d done=%0b busy=%0b",
                     nm, idx, s, c, d, b, es, ec, ed, eb);
        end else begin
            passed++;
        end
    endtask

    task automatic check_both(input string nm,
                              input logic [1:0] s0, input logic [W-1:0] c0, input logic d0,
                              input logic [1:0] s1, input logic [W-1:0] c1, input logic d1);
        chk(nm, 0, bus0.state, bus0.count, bus0.done, bus0.busy, s0, c0, d0);
        chk(nm, 1, bus1.state, bus1.count, bus1.done, bus1.busy, s1, c1, d1);
    endtask

    task automatic drive(input logic rst, input logic st, input logic xx,
                         input logic [W-1:0] tg, input logic ak);
        reset = rst; start = st; x = xx; target = tg; ack = ak;
    endtask

    // Behavioural reference: phase 0=idle, 1=waiting for x, 2=counting.
    int m_phase[2];
    int m_cnt[2];
    int m_tgt[2];
    int m_done[2];

    task automatic model_step(input int m);
        int  ph, cn, dn;
        ph = m_phase[m]; cn = m_cnt[m]; dn = m_done[m];
        if (reset) begin
            m_phase[m] = 0; m_cnt[m] = 0; m_done[m] = 0; m_tgt[m] = 0;
            return;
        end
        if (ack) dn = 0;
        if (m_phase[m] == 0) begin
            if (start) begin
                cn = 0;
                if (int'(target) == 0) dn = 1;
                else begin
                    m_tgt[m] = int'(target);
                    dn = 0;
                    ph = 1;
                end
            end
        end else if (m_phase[m] == 1) begin
            if (x) begin cn = cn + 1; ph = 2; end
        end else begin
            if (cn == m_tgt[m]) begin dn = 1; ph = 0; end
            else if (x) cn = cn + 1;
            else begin ph = 1; if (m == 1) cn = 0; end
        end
        m_phase[m] = ph; m_cnt[m] = cn; m_done[m] = dn;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Reset and a straight run to target 5.
        add(1,0,0, 0,0,  0,0,0,  0,0,0);
        add(0,1,0, 5,0,  1,0,0,  1,0,0);
        for (int k = 1; k <= 5; k++)
            add(0,0,1, 0,0,  2,k[W-1:0],0,  2,k[W-1:0],0);
        add(0,0,1, 0,0,  0,5,1,  0,5,1);
        add(0,0,0, 0,0,  0,5,1,  0,5,1);
        add(0,0,0, 0,1,  0,5,0,  0,5,0);
        // Gapped run to target 4: cumulative vs consecutive.
        add(0,1,0, 4,0,  1,0,0,  1,0,0);
        add(0,0,1, 0,0,  2,1,0,  2,1,0);
        add(0,0,1, 0,0,  2,2,0,  2,2,0);
        add(0,0,0, 0,0,  1,2,0,  1,0,0);
        add(0,0,0, 0,0,  1,2,0,  1,0,0);
        add(0,0,1, 0,0,  2,3,0,  2,1,0);
        add(0,0,1, 0,0,  2,4,0,  2,2,0);
        add(0,0,1, 0,0,  0,4,1,  2,3,0);
        add(0,0,1, 0,0,  0,4,1,  2,4,0);
        // ack in the done-setting cycle of dut1; plain clear for dut0.
        add(0,0,1, 0,1,  0,4,0,  0,4,1);
        // Zero target completes at once without leaving IDLE.
        add(0,1,0, 0,0,  0,0,1,  0,0,1);
        add(0,0,0, 0,1,  0,0,0,  0,0,0);
        // Reset in RUN at count 3, beating start/x/ack.
        add(0,1,0, 9,0,  1,0,0,  1,0,0);
        add(0,0,1, 0,0,  2,1,0,  2,1,0);
        add(0,0,1, 0,0,  2,2,0,  2,2,0);
        add(0,0,1, 0,0,  2,3,0,  2,3,0);
        add(1,1,1, 7,1,  0,0,0,  0,0,0);
        add(0,0,1, 7,1,  0,0,0,  0,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].xx, tbl[i].tg, tbl[i].ak);
            @(posedge clk); #1;
            check_both($sformatf("vec%0d", i),
                       tbl[i].s0, tbl[i].c0, tbl[i].d0, tbl[i].s1, tbl[i].c1, tbl[i].d1);
        end

        // Full-scale target: no wrap, and a start/target change in RUN is ignored.
        drive(1'b0, 1'b1, 1'b0, 4'd15, 1'b0);
        @(posedge clk); #1;
        check_both("max_arm", 2'd1, 4'd0, 1'b0, 2'd1, 4'd0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            drive(1'b0, (k == 7), 1'b1, (k == 7) ? 4'd3 : 4'd15, 1'b0);
            @(posedge clk); #1;
            check_both($sformatf("max_run%0d", k), 2'd2, k[W-1:0], 1'b0, 2'd2, k[W-1:0], 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        @(posedge clk); #1;
        check_both("max_done", 2'd0, 4'd15, 1'b1, 2'd0, 4'd15, 1'b1);

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 3000; n++) begin
            drive((n == 0) || ($urandom_range(0, 99) == 0),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6)),
                  $urandom_range(0, 9) == 0);
            model_step(0);
            model_step(1);
            @(posedge clk); #1;
            check_both($sformatf("rand%0d", n),
                       2'(m_phase[0]), W'(m_cnt[0]), m_done[0] != 0,
                       2'(m_phase[1]), W'(m_cnt[1]), m_done[1] != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/asm_run_counter.md
ASM_RUN_COUNTER -- requirements
Module: asm_run_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter and target width in bits, legal range 2..16.
REQ-002 Parameter MODE, default 0: 0 = cumulative (count held when x drops); 1 = consecutive (count cleared when x drops).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a measurement; sampled only in IDLE.
REQ-006 x  input  1  qualifier input being counted.
REQ-007 target  input  WIDTH  terminal count; latched on the accepted start.
REQ-008 ack  input  1  clears done.
REQ-009 count  output  WIDTH  current count value.
REQ-010 busy  output  1  high in ARM or RUN.
REQ-011 done  output  1  sticky completion flag (G).
REQ-012 state  output  2  state code: IDLE=0, ARM=1, RUN=2; code 3 is unused.

Function
REQ-013 The block SHALL be a registered Moore FSM with states IDLE, ARM and RUN, and all outputs SHALL come directly from registers.
REQ-014 IDLE: when start=1 and target!=0, the block SHALL set count<=0, latch target_q<=target, clear done and go to ARM.
REQ-015 IDLE: when start=1 and target==0, the block SHALL set count<=0 and done<=1, and SHALL stay in IDLE without entering ARM.
REQ-016 ARM: when x=1, the block SHALL set count<=count+1 and go to RUN; when x=0, it SHALL hold count and stay in ARM.
REQ-017 RUN, priority 1: when count==target_q, the block SHALL set done<=1, go to IDLE and hold count; this check SHALL take precedence over x.
REQ-018 RUN, priority 2: otherwise, when x=1, the block SHALL set count<=count+1 and stay in RUN.
REQ-019 RUN, priority 3: otherwise, when x=0, the block SHALL go to ARM; MODE=0 holds count, MODE=1 sets count<=0.
REQ-020 Count SHALL never exceed target_q and SHALL never wrap; the largest legal target is 2^WIDTH-1.
REQ-021 Latency: with start sampled at edge E0 and x=1 from E1 onward, count SHALL equal k after edge Ek, and done SHALL rise after edge E(N+1), where N=target.
REQ-022 start SHALL be ignored while busy=1; changes on target while busy SHALL have no effect.
REQ-023 ack=1 SHALL clear done in any state.
REQ-024 If done is being set and ack=1 in the same cycle, setting done SHALL win.
REQ-025 count SHALL hold its final value in IDLE until the next accepted start.
REQ-026 busy SHALL equal (state==ARM) or (state==RUN).
REQ-027 Unused state code 3 SHALL recover to IDLE on the next edge, with count and done unchanged.

Reset
REQ-028 With reset=1 at a rising edge, the block SHALL set state=IDLE, count=0, done=0, busy=0 and target_q=0.
REQ-029 reset SHALL take priority over start, x and ack, including mid-measurement in ARM or RUN.
REQ-030 After reset, no output SHALL change until a start is accepted.

Verification (WIDTH=4)
REQ-031 MODE=0, target=5, start pulse, x=1 continuously -> count steps 1..5, done=1 after the 6th edge following start, state returns to IDLE, count stays at 5.
REQ-032 MODE=0, target=4, x pattern 1,1,0,0,1,1 -> state goes RUN then ARM then RUN, count holds at 2 during the gap, done sets after count reaches 4.
REQ-033 MODE=1, same stimulus as REQ-032 -> count resets to 0 on the x drop, done only after 4 consecutive x=1 cycles.
REQ-034 target=0 with start -> done=1 on the next edge, state stays IDLE (0), busy never asserts.
REQ-035 target=15 with x held high -> count reaches 15 without wrap, done sets; a start pulse while in RUN is ignored.
REQ-036 reset asserted in RUN with count=3 -> next edge gives state=0, count=0, done=0; ack asserted together with the done-setting cycle -> done=1.
